note_field_scroller: RTL and testbench



---
 rtl/ddr_pkg.sv | 23 ++
 rtl/note_lfsr.sv | 20 ++
 rtl/note_field_scroller.sv | 117 +++++++++++
 tb/tb_note_field_scroller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared constants, state type and frame bit mapping
// for the note field and its array driver.
package ddr_pkg;

   localparam int NUM_COLS = 4;
   localparam int NUM_ROWS = 8;
   localparam int FRAME_W  = 36;

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      OVER
   } state_t;

   function automatic int green_idx(input int c, input int r);
      return c * NUM_ROWS + r;
   endfunction

   function automatic int orange_idx(input int c);
      return NUM_COLS * NUM_ROWS + c;
   endfunction

endpackage

// File: rtl/note_lfsr.sv
// 8-bit Fibonacci LFSR, taps 8/6/5/4, advancing
// only when en is high.
module note_lfsr #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic [7:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= SEED;
      end else if (en) begin
         q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
      end
   end

endmodule

// File: rtl/note_field_scroller.sv
// Scrolls pseudo-random notes down four columns and
// judges key presses at the target row.
module note_field_scroller
   import ddr_pkg::*;
#(
   parameter int         STEP_DIV   = 12500000,
   parameter int         TARGET_ROW = 6,
   parameter int         MAX_MISS   = 10,
   parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
   input  logic               CLOCK,
   input  logic               RESET,
   input  logic               ENABLE,
   input  logic [3:0]         KEY,
   output logic [FRAME_W-1:0] FRAME,
   output logic [7:0]         SCORE,
   output logic [7:0]         MISSES,
   output logic               HIT,
   output logic               MISS,
   output logic               GAME_OVER
);

   state_t      state_q, state_d;
   logic [31:0] div_q;
   logic [3:0]  key_q, press, hits, inj, orange_q;
   logic [7:0]  col_q [NUM_COLS];
   logic [7:0]  col_d [NUM_COLS];
   logic [7:0]  lfsr;
   logic        act, tick;
   logic [2:0]  nh, nm;
   logic [8:0]  score_sum, miss_sum;

   note_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk (CLOCK),
      .rst (RESET),
      .en  (tick),
      .q   (lfsr)
   );

   assign act   = (state_q == PLAY) && ENABLE;
   assign tick  = act && (div_q == 32'(STEP_DIV - 1));
   assign press = KEY & ~key_q;

   assign GAME_OVER = (state_q == OVER);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (ENABLE) state_d = PLAY;
         PLAY:    if (MISSES >= 8'(MAX_MISS)) state_d = OVER;
         OVER:    state_d = OVER;
         default: state_d = IDLE;
      endcase
   end

   // Hits clear their bit before the step shift is applied.
   always_comb begin
      hits = '0;
      inj  = '0;
      nh   = '0;
      nm   = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
         hits[c]  = act & press[c] & col_q[c][TARGET_ROW];
         col_d[c] = col_q[c] & ~(8'(hits[c]) << TARGET_ROW);
         nh       = nh + 3'(hits[c]);
      end
      if (lfsr[7]) inj[lfsr[1:0]] = 1'b1;
      if (tick) begin
         for (int c = 0; c < NUM_COLS; c++) begin
            nm       = nm + 3'(col_d[c][7]);
            col_d[c] = {col_d[c][6:0], inj[c]};
         end
      end
   end

   assign score_sum = {1'b0, SCORE} + 9'(nh);
   assign miss_sum  = {1'b0, MISSES} + 9'(nm);

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q  <= IDLE;
         div_q    <= '0;
         key_q    <= '0;
         orange_q <= '0;
         SCORE    <= '0;
         MISSES   <= '0;
         HIT      <= 1'b0;
         MISS     <= 1'b0;
         for (int c = 0; c < NUM_COLS; c++) col_q[c] <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= KEY;
         HIT     <= 1'b0;
         MISS    <= 1'b0;
         if (act) begin
            div_q    <= tick ? '0 : div_q + 32'd1;
            orange_q <= tick ? hits : (orange_q | hits);
            SCORE    <= score_sum[8] ? 8'hFF : score_sum[7:0];
            MISSES   <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
            HIT      <= |hits;
            MISS     <= (nm != 3'd0);
            for (int c = 0; c < NUM_COLS; c++) col_q[c] <= col_d[c];
         end
      end
   end

   always_comb begin
      FRAME = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
         for (int r = 0; r < NUM_ROWS; r++) begin
            FRAME[green_idx(c, r)] = col_q[c][r];
         end
         FRAME[orange_idx(c)] = orange_q[c];
      end
   end

endmodule

// File: tb/tb_note_field_scroller.sv
// Directed and random checks of note_field_scroller
// against a grid-of-notes reference model.
module tb_note_field_scroller;

   localparam int SD = 4;

   logic        CLOCK = 1'b0;
   logic        RESET, ENABLE;
   logic [3:0]  KEY;
   logic [35:0] FRAME;
   logic [7:0]  SCORE, MISSES;
   logic        HIT, MISS, GAME_OVER;

   int checks = 0;
   int errors = 0;

   note_field_scroller #(.STEP_DIV(SD)) dut (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .ENABLE    (ENABLE),
      .KEY       (KEY),
      .FRAME     (FRAME),
      .SCORE     (SCORE),
      .MISSES    (MISSES),
      .HIT       (HIT),
      .MISS      (MISS),
      .GAME_OVER (GAME_OVER)
   );

   always #5 CLOCK = ~CLOCK;

   bit       note [4][8];
   bit [3:0] m_or, m_kq;
   bit [7:0] m_lfsr;
   int       m_score, m_miss, m_div, m_st;
   bit       m_hit, m_missp, m_tk;

   function automatic logic [35:0] mframe();
      logic [35:0] f = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 8; r++) f[c*8+r] = note[c][r];
         f[32+c] = m_or[c];
      end
      return f;
   endfunction

   // m_st: 0 idle, 1 playing, 2 over
   task automatic model(input bit rst, input bit en, input bit [3:0] k);
      int nh, nm, old_miss;
      bit act;
      bit [3:0] pr, hm;
      m_tk = 0;
      if (rst) begin
         foreach (note[c, r]) note[c][r] = 0;
         m_or = 0; m_kq = 0; m_lfsr = 8'hA5;
         m_score = 0; m_miss = 0; m_div = 0; m_st = 0;
         m_hit = 0; m_missp = 0;
         return;
      end
      pr = k & ~m_kq;
      m_kq = k;
      act = (m_st == 1) && en;
      old_miss = m_miss;
      nh = 0; nm = 0; hm = 0;
      if (act) begin
         for (int c = 0; c < 4; c++)
            if (pr[c] && note[c][6]) begin
               note[c][6] = 0; nh++; hm[c] = 1;
            end
         if (m_div == SD - 1) begin
            m_tk = 1; m_div = 0;
            for (int c = 0; c < 4; c++) begin
               if (note[c][7]) nm++;
               for (int r = 7; r > 0; r--) note[c][r] = note[c][r-1];
               note[c][0] = 0;
            end
            if (m_lfsr[7]) note[m_lfsr[1:0]][0] = 1;
            m_lfsr = {m_lfsr[6:0],
                      m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            m_or = hm;
         end else begin
            m_div++;
            m_or |= hm;
         end
      end
      m_score = (m_score + nh > 255) ? 255 : m_score + nh;
      m_miss  = (m_miss + nm > 255) ? 255 : m_miss + nm;
      m_hit   = nh > 0;
      m_missp = nm > 0;
      if (m_st == 0 && en) m_st = 1;
      else if (m_st == 1 && old_miss >= 10) m_st = 2;
   endtask

   task automatic chk(input string tag, input logic [35:0] got,
                      input logic [35:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input bit rst, input bit en, input bit [3:0] k);
      RESET = rst; ENABLE = en; KEY = k;
      model(rst, en, k);
      @(posedge CLOCK);
      #1;
      chk("frame", FRAME, mframe());
      chk("score", 36'(SCORE), 36'(m_score));
      chk("misses", 36'(MISSES), 36'(m_miss));
      chk("hit", 36'(HIT), 36'(m_hit));
      chk("miss", 36'(MISS), 36'(m_missp));
      chk("game_over", 36'(GAME_OVER), 36'(m_st == 2));
   endtask

   initial begin
      bit found;
      int s0, ms0, col;
      logic [35:0] fr;

      // reset hold with keys and enable high
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 4'hF);
         chk("rst_frame", FRAME, 36'h0);
         chk("rst_gover", 36'(GAME_OVER), 36'h0);
      end
      step(0, 1, 4'h0);

      // first injection: seed A5 puts a note in column 1
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(0, 1, 4'h0);
         found = m_tk;
      end
      chk("first_tick_seen", 36'(found), 36'h1);
      chk("first_inj", FRAME, 36'h100);

      // hit column 1 at the target row
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (note[1][6]) begin
            step(0, 1, 4'h2);
            found = 1;
         end else begin
            step(0, 1, 4'h0);
         end
      end
      chk("hit_seen", 36'(found), 36'h1);
      chk("hit_score", 36'(SCORE), 36'h1);
      chk("hit_pulse", 36'(HIT), 36'h1);
      chk("hit_orange", 36'(FRAME[33]), 36'h1);
      chk("hit_cleared", 36'(FRAME[14]), 36'h0);
      step(0, 1, 4'h0);
      chk("hit_one_cycle", 36'(HIT), 36'h0);
      found = m_tk;
      for (int i = 0; i < 10 && !found; i++) begin
         step(0, 1, 4'h0);
         found = m_tk;
      end
      chk("orange_clear", 36'(FRAME[33]), 36'h0);

      // let a note fall out of row 7
      found = 0;
      ms0 = m_miss;
      for (int i = 0; i < 300 && !found; i++) begin
         step(0, 1, 4'h0);
         found = m_missp;
      end
      chk("miss_seen", 36'(found), 36'h1);
      chk("miss_pulse", 36'(MISS), 36'h1);
      chk("miss_count", 36'(MISSES), 36'(ms0 + 1));

      // press edge coincident with a tick
      found = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         col = -1;
         for (int c = 0; c < 4; c++) if (note[c][6]) col = c;
         if (col >= 0 && m_st == 1 && m_div == SD - 1) begin
            s0 = m_score;
            step(0, 1, 4'(1 << col));
            found = 1;
            chk("coin_score", 36'(SCORE), 36'(s0 + 1));
            chk("coin_row7", 36'(FRAME[col*8+7]), 36'h0);
         end else begin
            step(0, 1, 4'h0);
         end
      end
      chk("coin_seen", 36'(found), 36'h1);
      step(0, 1, 4'h0);

      // pause: frame and score frozen, presses ignored
      fr = mframe();
      s0 = m_score;
      for (int i = 0; i < 10; i++) begin
         step(0, 0, (i == 3 || i == 4) ? 4'hF : 4'h0);
         chk("pause_frame", FRAME, fr);
         chk("pause_score", 36'(SCORE), 36'(s0));
      end

      // random play
      for (int i = 0; i < 300; i++) begin
         step(0, $urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)));
      end

      // run without presses to game over
      found = 0;
      for (int i = 0; i < 20000 && !found; i++) begin
         step(0, 1, 4'h0);
         found = (m_st == 2);
      end
      chk("gover_seen", 36'(found), 36'h1);
      chk("gover_flag", 36'(GAME_OVER), 36'h1);
      chk("gover_misses", 36'(MISSES >= 8'd10), 36'h1);
      fr  = mframe();
      s0  = m_score;
      ms0 = m_miss;
      for (int i = 0; i < 100; i++) begin
         step(0, 1, 4'($urandom_range(0, 15)));
         chk("over_frame", FRAME, fr);
         chk("over_score", 36'(SCORE), 36'(s0));
         chk("over_misses", 36'(MISSES), 36'(ms0));
         chk("over_sticky", 36'(GAME_OVER), 36'h1);
      end

      step(1, 1, 4'h0);
      chk("rst2_frame", FRAME, 36'h0);
      chk("rst2_score", 36'(SCORE), 36'h0);
      chk("rst2_misses", 36'(MISSES), 36'h0);
      chk("rst2_gover", 36'(GAME_OVER), 36'h0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
